// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
//   state_e      - arbiter FSM encoding
//   DIV_W        - operand width of the shared restoring divider
//   DIV_LATENCY  - cycles from the div_start cycle to the div_valid cycle
//   DBZ_QUOT     - quotient returned for a zero divisor
//   dbz_rem()    - remainder returned for a zero divisor
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int unsigned DIV_W       = 8;
    localparam int unsigned DIV_LATENCY = 17;

    localparam logic [DIV_W-1:0] DBZ_QUOT = '1;

    // A zero divisor leaves the whole dividend as the remainder.
    function automatic logic [DIV_W-1:0] dbz_rem(input logic [DIV_W-1:0] x);
        return x;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Bus bundle of the divider arbiter.
//   Requester side : req_valid/req_x/req_y in, req_ready out
//   Response side  : resp_valid/resp_id/resp_quot/resp_rem/resp_err out, resp_ready in
//   Divider side   : div_start/div_x/div_y out, div_valid/div_quot/div_rem in
// Modport slave is the arbiter view; master is the requester/divider view.
interface div_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]       req_ready;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [IW-1:0]            resp_id;
    logic [WIDTH-1:0]         resp_quot;
    logic [WIDTH-1:0]         resp_rem;
    logic                     resp_err;

    logic                     div_start;
    logic [WIDTH-1:0]         div_x;
    logic [WIDTH-1:0]         div_y;
    logic                     div_valid;
    logic [WIDTH-1:0]         div_quot;
    logic [WIDTH-1:0]         div_rem;

    modport slave (
        input  req_valid, req_x, req_y, resp_ready, div_valid, div_quot, div_rem,
        output req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err,
               div_start, div_x, div_y
    );

    modport master (
        output req_valid, req_x, req_y, resp_ready, div_valid, div_quot, div_rem,
        input  req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err,
               div_start, div_x, div_y
    );

endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr with wrap-around.
//   req   - request vector
//   ptr   - highest-priority index
//   grant - one-hot grant (all zero when no request)
//   idx   - encoded index of the grant
//   any   - at least one request present
module rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk N positions from ptr; the first hit wins.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one restoring divider between NUM_REQ requesters.
//   clk, rst  - clock and asynchronous active-low reset
//   bus       - div_arbiter_if.slave: request, response and divider channels
// A zero divisor is answered directly with an error response; a divider that
// stays silent for TIMEOUT cycles is abandoned with an error response.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = DIV_W,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // An illegal TIMEOUT is clamped so a nominal divider can still succeed.
    localparam int unsigned TMO = (TIMEOUT > DIV_LATENCY) ? TIMEOUT : DIV_LATENCY + 1;
    localparam int unsigned TW  = $clog2(TMO);

    state_e           state, state_next;

    logic [IW-1:0]    rr_ptr, rr_ptr_d;
    logic [IW-1:0]    cur_id, cur_id_d;
    logic [TW-1:0]    timer, timer_d;

    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] div_x_q, div_x_d;
    logic [WIDTH-1:0] div_y_q, div_y_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_quot_q, resp_quot_d;
    logic [WIDTH-1:0] resp_rem_q, resp_rem_d;
    logic             resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   pick_x, pick_y;
    logic               timed_out;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_x    = bus.req_x[32'(pick_idx)*WIDTH +: WIDTH];
    assign pick_y    = bus.req_y[32'(pick_idx)*WIDTH +: WIDTH];
    assign timed_out = (timer == TW'(TMO - 1));

    // Grant is only offered in IDLE and never while reset is applied.
    assign bus.req_ready = (rst && state == ST_IDLE) ? pick_grant : '0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = (pick_y == '0) ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.div_valid || timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        rr_ptr_d     = rr_ptr;
        cur_id_d     = cur_id;
        timer_d      = timer;
        div_start_d  = 1'b0;
        div_x_d      = div_x_q;
        div_y_d      = div_y_q;
        resp_valid_d = resp_valid_q;
        resp_quot_d  = resp_quot_q;
        resp_rem_d   = resp_rem_q;
        resp_err_d   = resp_err_q;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    cur_id_d = pick_idx;
                    rr_ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                    div_x_d  = pick_x;
                    div_y_d  = pick_y;
                    if (pick_y == '0) begin
                        resp_valid_d = 1'b1;
                        resp_quot_d  = WIDTH'(DBZ_QUOT);
                        resp_rem_d   = WIDTH'(dbz_rem(DIV_W'(pick_x)));
                        resp_err_d   = 1'b1;
                    end else begin
                        div_start_d = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
            end
            ST_WAIT: begin
                timer_d = timer + TW'(1);
                // A result in the timeout cycle still counts as success.
                if (bus.div_valid) begin
                    resp_valid_d = 1'b1;
                    resp_quot_d  = bus.div_quot;
                    resp_rem_d   = bus.div_rem;
                    resp_err_d   = 1'b0;
                end else if (timed_out) begin
                    resp_valid_d = 1'b1;
                    resp_quot_d  = '0;
                    resp_rem_d   = '0;
                    resp_err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            cur_id       <= '0;
            timer        <= '0;
            div_start_q  <= 1'b0;
            div_x_q      <= '0;
            div_y_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_quot_q  <= '0;
            resp_rem_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_d;
            cur_id       <= cur_id_d;
            timer        <= timer_d;
            div_start_q  <= div_start_d;
            div_x_q      <= div_x_d;
            div_y_q      <= div_y_d;
            resp_valid_q <= resp_valid_d;
            resp_quot_q  <= resp_quot_d;
            resp_rem_q   <= resp_rem_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.div_start  = div_start_q;
    assign bus.div_x      = div_x_q;
    assign bus.div_y      = div_y_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = cur_id;
    assign bus.resp_quot  = resp_quot_q;
    assign bus.resp_rem   = resp_rem_q;
    assign bus.resp_err   = resp_err_q;

endmodule
